// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard/SRAM arbiter.
package pipe_ctrl_pkg;

    localparam int unsigned WAIT_W = 4;

    localparam logic STALL_YES  = 1'b1;
    localparam logic STALL_NO   = 1'b0;
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic {
        CTRL_FETCH = 1'b0,
        CTRL_DATA  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates the shared SRAM between instruction fetch and
// data accesses, inserts load-use bubbles and squashes fetches after taken
// branches (deferring the squash while a data access owns the SRAM).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   id_loaduse    ID source matches the waddr of a load in EX
//   mem_req       MEM stage requests a data access
//   branch_taken  ID resolved a taken branch/jump
//   stall_pc/id/ex/mem  freeze PC, IF/ID, ID/EX, EX/MEM registers
//   flush_if      IF/ID loads a NOP on the next edge
//   mem_sel       SRAM owner: 0 = fetch, 1 = data
//
// Outputs are combinational decodes of the registered state and the current
// inputs so a request stalls the pipe in the cycle it is raised.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic id_loaduse,
    input  logic mem_req,
    input  logic branch_taken,
    output logic stall_pc,
    output logic stall_id,
    output logic stall_ex,
    output logic stall_mem,
    output logic flush_if,
    output logic mem_sel
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_WAIT - 1);

    ctrl_state_t       ctrl_state, ctrl_state_nxt;
    logic [WAIT_W-1:0] wait_cnt,   wait_cnt_nxt;
    logic              flush_pend, flush_pend_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_state <= CTRL_FETCH;
            wait_cnt   <= '0;
            flush_pend <= 1'b0;
        end else begin
            ctrl_state <= ctrl_state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        ctrl_state_nxt = ctrl_state;
        wait_cnt_nxt   = wait_cnt;
        flush_pend_nxt = flush_pend;
        stall_pc       = STALL_NO;
        stall_id       = STALL_NO;
        stall_ex       = STALL_NO;
        stall_mem      = STALL_NO;
        flush_if       = 1'b0;
        mem_sel        = 1'b0;

        // While reset is held every output stays at its idle value.
        if (rst != RST_ENABLE) begin
            unique case (ctrl_state)
                CTRL_FETCH: begin
                    if (mem_req) begin
                        // Whole pipe frozen; SRAM still on fetch this cycle.
                        // A branch seen now is remembered, since IF/ID cannot
                        // be flushed while it is stalled.
                        stall_pc       = STALL_YES;
                        stall_id       = STALL_YES;
                        stall_ex       = STALL_YES;
                        stall_mem      = STALL_YES;
                        ctrl_state_nxt = CTRL_DATA;
                        wait_cnt_nxt   = '0;
                        flush_pend_nxt = flush_pend | branch_taken;
                    end else if (id_loaduse) begin
                        // Bubble into ID/EX; branch is re-resolved afterwards.
                        stall_pc = STALL_YES;
                        stall_id = STALL_YES;
                    end else begin
                        flush_if       = branch_taken | flush_pend;
                        flush_pend_nxt = 1'b0;
                    end
                end
                CTRL_DATA: begin
                    mem_sel        = 1'b1;
                    stall_pc       = STALL_YES;
                    stall_id       = STALL_YES;
                    stall_ex       = STALL_YES;
                    // EX/MEM is released in the final owned cycle so the
                    // access retires as the SRAM returns to fetch.
                    stall_mem      = (wait_cnt == LAST_WAIT) ? STALL_NO : STALL_YES;
                    flush_pend_nxt = flush_pend | branch_taken;
                    if (wait_cnt == LAST_WAIT) begin
                        ctrl_state_nxt = CTRL_FETCH;
                        wait_cnt_nxt   = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
                default: ctrl_state_nxt = CTRL_FETCH;
            endcase
        end
    end

endmodule
